// File: rtl/cpu_pkg.sv
// Shared CPU execute-side types: ALU op codes, NZCV flag struct, skid buffer states.
// Configuration macro used by alu_result_stage: ALU_FLAG_BYPASS_EN.
package cpu_pkg;

    localparam int ALU_WIDTH = 64;

    typedef enum logic [2:0] {
        PASS_B = 3'b000,
        ADD    = 3'b010,
        SUB    = 3'b011,
        AND    = 3'b100,
        OR     = 3'b101,
        XOR    = 3'b110
    } alu_op_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_FULL  = 2'b10
    } skid_state_t;

    // Only add/sub produce meaningful carry and overflow.
    function automatic logic is_arith(input logic [2:0] code);
        return (code == ADD) || (code == SUB);
    endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// Two-entry valid/ready skid buffer; in_ready is registered so it never
// depends combinationally on out_ready.
//
// state      | meaning
// -----------+----------------------------------------------
// SKID_EMPTY | no entry held, out_valid low
// SKID_ONE   | main register holds the output entry
// SKID_FULL  | main and skid both hold entries, in_ready low
module alu_skid_buf
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    skid_state_t       state, state_nxt;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              ready_q;
    logic              accept;
    logic              xfer;
    logic              load_main;
    logic              load_skid;
    logic              main_from_skid;

    assign accept    = in_valid && ready_q;
    assign xfer      = out_valid && out_ready;
    assign in_ready  = ready_q;
    assign out_valid = (state != SKID_EMPTY);
    assign out_data  = main_q;

    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            SKID_EMPTY: begin
                if (accept) begin
                    load_main = 1'b1;
                    state_nxt = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (accept && xfer) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nxt = SKID_FULL;
                end else if (xfer) begin
                    state_nxt = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (xfer) begin
                    main_from_skid = 1'b1;
                    state_nxt      = SKID_ONE;
                end
            end
            default: state_nxt = SKID_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= SKID_EMPTY;
            ready_q <= 1'b1;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt != SKID_FULL);
            if (load_main) begin
                main_q <= in_data;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: derives NZCV, holds the architectural flag register and
// forwards {result, zero, rd} through a skid buffer. Option: ALU_FLAG_BYPASS_EN.
module alu_result_stage
    import cpu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int RD_W  = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_c_out,
    input  logic             in_c_msb,
    input  logic [2:0]       in_cntrl,
    input  logic             in_set_flags,
    input  logic [RD_W-1:0]  in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic [RD_W-1:0]  out_rd,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int PAY_W = WIDTH + 1 + RD_W;

    logic             accept;
    logic             flag_we;
    nzcv_t            nzcv_new;
    nzcv_t            flag_q;
    nzcv_t            flag_out;
    logic [PAY_W-1:0] pay_in;
    logic [PAY_W-1:0] pay_out;

    assign accept  = in_valid && in_ready;
    assign flag_we = accept && in_set_flags;

    always_comb begin
        nzcv_new.n = in_result[WIDTH-1];
        nzcv_new.z = (in_result == '0);
        nzcv_new.c = 1'b0;
        nzcv_new.v = 1'b0;
        if (is_arith(in_cntrl)) begin
            nzcv_new.c = in_c_out;
            nzcv_new.v = in_c_out ^ in_c_msb;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flag_q <= '0;
        end else if (flag_we) begin
            flag_q <= nzcv_new;
        end
    end

`ifdef ALU_FLAG_BYPASS_EN
    // Decode sees flags of an accepting flag-setter in the same cycle.
    assign flag_out = flag_we ? nzcv_new : flag_q;
`else
    assign flag_out = flag_q;
`endif

    assign flag_n = flag_out.n;
    assign flag_z = flag_out.z;
    assign flag_c = flag_out.c;
    assign flag_v = flag_out.v;

    assign pay_in = {in_result, nzcv_new.z, in_rd};

    alu_skid_buf #(
        .DATA_W (PAY_W)
    ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (pay_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (pay_out)
    );

    assign out_result = pay_out[PAY_W-1 -: WIDTH];
    assign out_zero   = pay_out[RD_W];
    assign out_rd     = pay_out[RD_W-1:0];

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage (honours ALU_FLAG_BYPASS_EN).
module tb_alu_result_stage;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_result;
    logic        in_c_out;
    logic        in_c_msb;
    logic [2:0]  in_cntrl;
    logic        in_set_flags;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic        out_zero;
    logic [4:0]  out_rd;
    logic        flag_n, flag_z, flag_c, flag_v;

    int checks = 0;
    int errors = 0;

    alu_result_stage #(.WIDTH(64), .RD_W(5)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_c_out     (in_c_out),
        .in_c_msb     (in_c_msb),
        .in_cntrl     (in_cntrl),
        .in_set_flags (in_set_flags),
        .in_rd        (in_rd),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_zero     (out_zero),
        .out_rd       (out_rd),
        .flag_n       (flag_n),
        .flag_z       (flag_z),
        .flag_c       (flag_c),
        .flag_v       (flag_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [63:0] r, input logic co, input logic cm,
                         input logic [2:0] op, input logic sf, input logic [4:0] rd);
        in_valid     = v;
        in_result    = r;
        in_c_out     = co;
        in_c_msb     = cm;
        in_cntrl     = op;
        in_set_flags = sf;
        in_rd        = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        drive(1'b0, 64'h0, 1'b0, 1'b0, 3'b000, 1'b0, 5'd0);
        out_ready = 1'b0;
        reset_n   = 1'b0;
        tick();
        tick();
        checks++;
        if ({out_valid, in_ready, out_zero} !== 3'b010) begin
            errors++;
            $display("FAIL reset_ctl: valid/ready/zero=%b expected 010", {out_valid, in_ready, out_zero});
        end
        checks++;
        if ({out_result, out_rd} !== 69'h0) begin
            errors++;
            $display("FAIL reset_data: result=%h rd=%0d expected 0/0", out_result, out_rd);
        end
        checks++;
        if ({flag_n, flag_z, flag_c, flag_v} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: nzcv=%b expected 0000", {flag_n, flag_z, flag_c, flag_v});
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_subs();
        logic [3:0] pre_exp;
        out_ready = 1'b0;
        drive(1'b1, 64'h0, 1'b1, 1'b1, 3'b011, 1'b1, 5'd5);
`ifdef ALU_FLAG_BYPASS_EN
        pre_exp = 4'b0110;
`else
        pre_exp = 4'b0000;
`endif
        #1;
        checks++;
        if ({flag_n, flag_z, flag_c, flag_v} !== pre_exp) begin
            errors++;
            $display("FAIL subs_flags_pre: nzcv=%b expected %b", {flag_n, flag_z, flag_c, flag_v}, pre_exp);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL subs_valid_pre: out_valid=%b expected 0", out_valid);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_zero, out_rd} !== {1'b1, 1'b1, 5'd5} || out_result !== 64'h0) begin
            errors++;
            $display("FAIL subs_out: valid=%b zero=%b rd=%0d result=%h expected 1 1 5 0",
                     out_valid, out_zero, out_rd, out_result);
        end
        checks++;
        if ({flag_n, flag_z, flag_c, flag_v} !== 4'b0110) begin
            errors++;
            $display("FAIL subs_flags: nzcv=%b expected 0110", {flag_n, flag_z, flag_c, flag_v});
        end
        drain();
    endtask

    task automatic test_non_flag();
        out_ready = 1'b0;
        drive(1'b1, 64'h0, 1'b1, 1'b0, 3'b100, 1'b0, 5'd7);
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_zero, out_rd} !== {1'b1, 1'b1, 5'd7}) begin
            errors++;
            $display("FAIL and_out: valid=%b zero=%b rd=%0d expected 1 1 7", out_valid, out_zero, out_rd);
        end
        checks++;
        if ({flag_n, flag_z, flag_c, flag_v} !== 4'b0110) begin
            errors++;
            $display("FAIL and_flags_hold: nzcv=%b expected 0110", {flag_n, flag_z, flag_c, flag_v});
        end
        drain();
    endtask

    task automatic test_adds_overflow();
        logic [3:0] pre_exp;
        out_ready = 1'b0;
        drive(1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 3'b010, 1'b1, 5'd9);
`ifdef ALU_FLAG_BYPASS_EN
        pre_exp = 4'b1001;
`else
        pre_exp = 4'b0110;
`endif
        #1;
        checks++;
        if ({flag_n, flag_z, flag_c, flag_v} !== pre_exp) begin
            errors++;
            $display("FAIL adds_flags_pre: nzcv=%b expected %b", {flag_n, flag_z, flag_c, flag_v}, pre_exp);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if ({flag_n, flag_z, flag_c, flag_v} !== 4'b1001) begin
            errors++;
            $display("FAIL adds_flags: nzcv=%b expected 1001", {flag_n, flag_z, flag_c, flag_v});
        end
        checks++;
        if (out_result !== 64'h8000_0000_0000_0000 || out_zero !== 1'b0) begin
            errors++;
            $display("FAIL adds_out: result=%h zero=%b expected 8000000000000000 0", out_result, out_zero);
        end
        drain();
        // Logic op with set_flags: carry in must not leak into C/V.
        out_ready = 1'b0;
        drive(1'b1, 64'h8000_0000_0000_0001, 1'b1, 1'b0, 3'b100, 1'b1, 5'd2);
        tick();
        in_valid = 1'b0;
        checks++;
        if ({flag_n, flag_z, flag_c, flag_v} !== 4'b1000) begin
            errors++;
            $display("FAIL ands_flags: nzcv=%b expected 1000", {flag_n, flag_z, flag_c, flag_v});
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [63:0] vals [3];
        logic [63:0] got [3];
        int          n_got;
        logic        acc;
        vals[0] = 64'h0000_0000_0000_00A1;
        vals[1] = 64'h0000_0000_0000_00B2;
        vals[2] = 64'h0000_0000_0000_00C3;
        out_ready = 1'b0;
        drive(1'b1, vals[0], 1'b0, 1'b0, 3'b101, 1'b0, 5'd1);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_a: in_ready=%b expected 1", in_ready);
        end
        tick();
        drive(1'b1, vals[1], 1'b0, 1'b0, 3'b101, 1'b0, 5'd2);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_b: in_ready=%b expected 1", in_ready);
        end
        tick();
        drive(1'b1, vals[2], 1'b0, 1'b0, 3'b101, 1'b0, 5'd3);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_c: in_ready=%b expected 0", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_result !== vals[0] || out_rd !== 5'd1) begin
            errors++;
            $display("FAIL bp_stable: valid=%b result=%h rd=%0d expected 1 %h 1",
                     out_valid, out_result, out_rd, vals[0]);
        end
        out_ready = 1'b1;
        n_got = 0;
        for (int cyc = 0; cyc < 10 && n_got < 3; cyc++) begin
            #1;
            acc = in_valid && in_ready;
            if (out_valid) begin
                got[n_got] = out_result;
                n_got++;
            end
            tick();
            if (acc) in_valid = 1'b0;
        end
        checks++;
        if (n_got !== 3) begin
            errors++;
            $display("FAIL bp_count: got %0d entries expected 3", n_got);
        end
        for (int i = 0; i < n_got; i++) begin
            checks++;
            if (got[i] !== vals[i]) begin
                errors++;
                $display("FAIL bp_order[%0d]: result=%h expected %h", i, got[i], vals[i]);
            end
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_dup: out_valid=%b expected 0", out_valid);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [63:0] v;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            v = 64'h1000 + 64'(i);
            drive(1'b1, v, 1'b0, 1'b0, 3'b110, 1'b0, 5'(i));
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: in_ready=%b expected 1", i, in_ready);
            end
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b1 || out_result !== v - 64'd1) begin
                    errors++;
                    $display("FAIL b2b_out[%0d]: valid=%b result=%h expected 1 %h",
                             i, out_valid, out_result, v - 64'd1);
                end
            end
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_result !== 64'h1004) begin
            errors++;
            $display("FAIL b2b_last: valid=%b result=%h expected 1 1004", out_valid, out_result);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_empty: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 3'b011, 1'b1, 5'd11);
        tick();
        drive(1'b1, 64'h55, 1'b0, 1'b0, 3'b000, 1'b0, 5'd12);
        tick();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || {flag_n, flag_z, flag_c, flag_v} !== 4'b1011) begin
            errors++;
            $display("FAIL full_pre: in_ready=%b nzcv=%b expected 0 1011",
                     in_ready, {flag_n, flag_z, flag_c, flag_v});
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, flag_n, flag_z, flag_c, flag_v} !== 6'b010000) begin
            errors++;
            $display("FAIL async_reset: valid/ready/nzcv=%b expected 010000",
                     {out_valid, in_ready, flag_n, flag_z, flag_c, flag_v});
        end
        checks++;
        if (out_result !== 64'h0 || out_rd !== 5'd0 || out_zero !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_data: result=%h rd=%0d zero=%b expected 0 0 0",
                     out_result, out_rd, out_zero);
        end
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b1, 64'h77, 1'b0, 1'b0, 3'b000, 1'b0, 5'd13);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_result !== 64'h77 || out_rd !== 5'd13) begin
            errors++;
            $display("FAIL post_reset_accept: valid=%b result=%h rd=%0d expected 1 77 13",
                     out_valid, out_result, out_rd);
        end
        drain();
    endtask

    initial begin
        reset_n   = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 64'h0, 1'b0, 1'b0, 3'b000, 1'b0, 5'd0);
        test_reset();
        test_subs();
        test_non_flag();
        test_adds_overflow();
        test_backpressure();
        test_back_to_back();
        test_reset_full();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
